// File: rtl/ivar_loop_sequencer.sv
// ivar_loop_sequencer: walks a signed 2-D (i,j) iteration domain in row-major order
// and presents each point on a valid/ready handshake.
module ivar_loop_sequencer #(
  parameter int ITERATION_VARIABLE_WIDTH = 16
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        cfg_load,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0]  cfg_i_min,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0]  cfg_i_max,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0]  cfg_j_min,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0]  cfg_j_max,
  input  logic        [ITERATION_VARIABLE_WIDTH-1:0]  cfg_j_step,
  input  logic                                        start,
  input  logic                                        abort,
  output logic signed [ITERATION_VARIABLE_WIDTH-1:0]  ivar_i,
  output logic signed [ITERATION_VARIABLE_WIDTH-1:0]  ivar_j,
  output logic                                        ivar_valid,
  input  logic                                        ivar_ready,
  output logic                                        ivar_last,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        cfg_err
);
  localparam int W = ITERATION_VARIABLE_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q;
  logic signed [W-1:0] i_min_q, i_max_q, j_min_q, j_max_q, i_q, j_q;
  logic [W-1:0] step_q, step_eff;
  logic signed [W:0] j_sum;
  logic done_q, err_q, row_end, empty;
  assign step_eff = (step_q == '0) ? {{(W-1){1'b0}}, 1'b1} : step_q;
  // One extra bit keeps j+step from wrapping, so a huge stride simply ends the row.
  assign j_sum = {j_q[W-1], j_q} + $signed({1'b0, step_eff});
  assign row_end = j_sum > $signed({j_max_q[W-1], j_max_q});
  assign empty = (i_min_q > i_max_q) || (j_min_q > j_max_q);
  assign ivar_valid = state_q == RUN;
  assign busy = state_q == RUN;
  assign ivar_last = ivar_valid && (i_q == i_max_q) && row_end;
  assign ivar_i = i_q;
  assign ivar_j = j_q;
  assign done = done_q;
  assign cfg_err = err_q;
  always_ff @(posedge clk) begin : seq
    if (!reset_n) begin
      state_q <= IDLE;
      i_min_q <= '0;
      i_max_q <= '0;
      j_min_q <= '0;
      j_max_q <= '0;
      step_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_load) begin
            i_min_q <= cfg_i_min;
            i_max_q <= cfg_i_max;
            j_min_q <= cfg_j_min;
            j_max_q <= cfg_j_max;
            step_q  <= cfg_j_step;
            err_q   <= 1'b0;
          end
          if (start && empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (start) begin
            state_q <= RUN;
            i_q     <= i_min_q;
            j_q     <= j_min_q;
          end
        end
        RUN: begin
          // Completion is caught before any increment, so i never passes i_max.
          if (abort) state_q <= IDLE;
          else if (ivar_ready && ivar_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (ivar_ready && row_end) begin
            j_q <= j_min_q;
            i_q <= i_q + 1'b1;
          end else if (ivar_ready) j_q <= j_sum[W-1:0];
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ivar_loop_sequencer.sv
// tb_ivar_loop_sequencer: directed scenarios with hand-computed expected points.
module tb_ivar_loop_sequencer;
  logic clk = 1'b0;
  logic reset_n, cfg_load, start, abort, ivar_ready;
  logic signed [15:0] cfg_i_min, cfg_i_max, cfg_j_min, cfg_j_max;
  logic [15:0] cfg_j_step;
  logic signed [15:0] ivar_i, ivar_j;
  logic ivar_valid, ivar_last, busy, done, cfg_err;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ivar_loop_sequencer #(.ITERATION_VARIABLE_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load),
    .cfg_i_min(cfg_i_min), .cfg_i_max(cfg_i_max), .cfg_j_min(cfg_j_min),
    .cfg_j_max(cfg_j_max), .cfg_j_step(cfg_j_step), .start(start), .abort(abort),
    .ivar_i(ivar_i), .ivar_j(ivar_j), .ivar_valid(ivar_valid), .ivar_ready(ivar_ready),
    .ivar_last(ivar_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int imin, input int imax, input int jmin, input int jmax, input int st);
    cfg_i_min = 16'(imin);
    cfg_i_max = 16'(imax);
    cfg_j_min = 16'(jmin);
    cfg_j_max = 16'(jmax);
    cfg_j_step = 16'(st);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({ivar_i, ivar_j, ivar_valid, ivar_last, busy, done, cfg_err} !== 37'd0) begin
      errors++;
      $display("FAIL reset outputs: got i=%0d j=%0d v=%b l=%b b=%b d=%b e=%b, want all 0",
               ivar_i, ivar_j, ivar_valid, ivar_last, busy, done, cfg_err);
    end
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_basic();
    logic signed [15:0] ei, ej;
    load(0, 1, 0, 2, 1);
    ivar_ready = 1'b1;
    do_start();
    for (int b = 0; b < 6; b++) begin
      ei = 16'(b / 3);
      ej = 16'(b % 3);
      checks++;
      if (ivar_valid !== 1'b1 || busy !== 1'b1 || ivar_i !== ei || ivar_j !== ej || ivar_last !== (b == 5)) begin
        errors++;
        $display("FAIL basic beat %0d: got v=%b b=%b (%0d,%0d) l=%b, want v=1 b=1 (%0d,%0d) l=%b",
                 b, ivar_valid, busy, ivar_i, ivar_j, ivar_last, ei, ej, b == 5);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || ivar_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic completion: got d=%b v=%b b=%b, want d=1 v=0 b=0", done, ivar_valid, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ivar_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic start-in-done: got d=%b b=%b v=%b, want d=0 b=0 v=0", done, busy, ivar_valid);
    end
    tick();
  endtask
  task automatic test_backpressure();
    logic signed [15:0] ei, ej;
    load(-2, -1, -1, 3, 2);
    ivar_ready = 1'b0;
    do_start();
    for (int b = 0; b < 6; b++) begin
      ei = 16'(-2 + b / 3);
      ej = 16'(-1 + 2 * (b % 3));
      ivar_ready = 1'b0;
      tick();
      checks++;
      if (ivar_valid !== 1'b1 || ivar_i !== ei || ivar_j !== ej || ivar_last !== (b == 5)) begin
        errors++;
        $display("FAIL backpressure hold %0d: got v=%b (%0d,%0d) l=%b, want v=1 (%0d,%0d) l=%b",
                 b, ivar_valid, ivar_i, ivar_j, ivar_last, ei, ej, b == 5);
      end
      ivar_ready = 1'b1;
      tick();
    end
    checks++;
    if (done !== 1'b1 || ivar_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure completion: got d=%b v=%b, want d=1 v=0", done, ivar_valid);
    end
    tick();
  endtask
  task automatic test_overflow();
    logic signed [15:0] ei, ej;
    load(32766, 32767, 32765, 32767, 2);
    ivar_ready = 1'b1;
    do_start();
    for (int b = 0; b < 4; b++) begin
      ei = 16'(32766 + b / 2);
      ej = 16'(32765 + 2 * (b % 2));
      checks++;
      if (ivar_valid !== 1'b1 || ivar_i !== ei || ivar_j !== ej || ivar_last !== (b == 3)) begin
        errors++;
        $display("FAIL overflow beat %0d: got v=%b (%0d,%0d) l=%b, want v=1 (%0d,%0d) l=%b",
                 b, ivar_valid, ivar_i, ivar_j, ivar_last, ei, ej, b == 3);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || ivar_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow completion: got d=%b v=%b, want d=1 v=0", done, ivar_valid);
    end
    tick();
  endtask
  task automatic test_empty();
    load(0, 0, 5, 4, 1);
    do_start();
    checks++;
    if (done !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b0 || ivar_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty start: got d=%b e=%b b=%b v=%b, want d=1 e=1 b=0 v=0", done, cfg_err, busy, ivar_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cfg_err !== 1'b1 || ivar_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty sticky: got d=%b e=%b v=%b, want d=0 e=1 v=0", done, cfg_err, ivar_valid);
    end
    load(0, 3, 0, 3, 1);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL empty clear: got e=%b, want e=0", cfg_err);
    end
  endtask
  task automatic test_abort();
    int beats;
    logic signed [15:0] li, lj;
    ivar_ready = 1'b1;
    do_start();
    tick();
    tick();
    tick();
    cfg_i_max = 16'sd0;
    cfg_j_max = 16'sd0;
    cfg_load = 1'b1;
    abort = 1'b1;
    tick();
    cfg_load = 1'b0;
    abort = 1'b0;
    checks++;
    if (ivar_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ivar_i !== 16'sd0 || ivar_j !== 16'sd3) begin
      errors++;
      $display("FAIL abort: got v=%b b=%b d=%b (%0d,%0d), want v=0 b=0 d=0 (0,3)",
               ivar_valid, busy, done, ivar_i, ivar_j);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort no-done: got d=%b, want d=0", done);
    end
    do_start();
    beats = 0;
    li = 0;
    lj = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (ivar_valid) begin
        beats++;
        li = ivar_i;
        lj = ivar_j;
      end
      tick();
    end
    checks++;
    if (beats != 16 || li !== 16'sd3 || lj !== 16'sd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL abort locked-cfg rerun: got %0d beats last (%0d,%0d) d=%b, want 16 beats last (3,3) d=1",
               beats, li, lj, done);
    end
    tick();
  endtask
  task automatic test_reset_mid_run();
    ivar_ready = 1'b1;
    do_start();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({ivar_i, ivar_j, ivar_valid, ivar_last, busy, done, cfg_err} !== 37'd0) begin
      errors++;
      $display("FAIL reset mid-run: got i=%0d j=%0d v=%b l=%b b=%b d=%b e=%b, want all 0",
               ivar_i, ivar_j, ivar_valid, ivar_last, busy, done, cfg_err);
    end
    do_start();
    checks++;
    if (ivar_valid !== 1'b1 || ivar_i !== 16'sd0 || ivar_j !== 16'sd0 || ivar_last !== 1'b1) begin
      errors++;
      $display("FAIL reset single point: got v=%b (%0d,%0d) l=%b, want v=1 (0,0) l=1",
               ivar_valid, ivar_i, ivar_j, ivar_last);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset single done: got d=%b b=%b, want d=1 b=0", done, busy);
    end
    tick();
  endtask
  initial begin
    reset_n = 1'b0;
    cfg_load = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ivar_ready = 1'b0;
    cfg_i_min = '0;
    cfg_i_max = '0;
    cfg_j_min = '0;
    cfg_j_max = '0;
    cfg_j_step = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_empty();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ivar_loop_sequencer.md
# ivar_loop_sequencer

Sequencer for the global controller's iteration variables. It walks a two-dimensional signed iteration domain, outer variable i and inner variable j, in row-major order. Each (i, j) point is presented on a valid/ready handshake to the downstream min/max range comparators and condition logic. Bounds are loaded from configuration registers, and each run is started, aborted and completed under control of the global controller FSM.

## Interface

Parameters:
- ITERATION_VARIABLE_WIDTH, 16, width W of all iteration variables and bounds (signed two's complement).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- cfg_load  in  1  latch all cfg_* inputs; honoured only in IDLE
- cfg_i_min, cfg_i_max  in  W  signed outer bounds, inclusive
- cfg_j_min, cfg_j_max  in  W  signed inner bounds, inclusive
- cfg_j_step  in  W  unsigned inner stride; a value of 0 is treated as 1
- start  in  1  begin a run; honoured only in IDLE
- abort  in  1  terminate a run; honoured only in RUN
- ivar_i, ivar_j  out  W  current iteration point (signed)
- ivar_valid  out  1  iteration point valid
- ivar_ready  in  1  consumer accepts the point
- ivar_last  out  1  current point is the final point of the domain
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on normal completion
- cfg_err  out  1  sticky flag for an empty domain

## Operation

- **States.**
  - IDLE → RUN when start=1 and the domain is non-empty.
  - IDLE → DONE when start=1 and the domain is empty.
  - RUN → DONE when the point with ivar_last=1 is accepted.
  - RUN → IDLE on abort.
  - DONE → IDLE unconditionally.
- **Domain.** The domain is empty when i_min>i_max or j_min>j_max, using signed compares. An empty-domain start sets cfg_err, produces no beats, and still pulses done. cfg_err clears on the next honoured cfg_load.
- **Start.** On an honoured start, ivar_i←i_min and ivar_j←j_min.
- **Advance.** On each accepted beat (ivar_valid && ivar_ready):
  - If j+step > j_max, then j←j_min and i←i+1.
  - Otherwise j←j+step.
- **Sum width.** j+step is computed in W+1 bits, signed j plus zero-extended step. It never wraps; a large step simply ends the row.
- **Outer variable.** i is never incremented past i_max. Completion is detected before the increment, so i cannot overflow even when i_max equals the maximum signed value.
- **ivar_last.** Combinational: (i==i_max) && (j+step > j_max), valid only while ivar_valid=1.
- **Configuration lock.** Config registers are frozen outside IDLE. cfg_load or start outside IDLE is ignored.
- **Abort vs. accept.** abort has priority over an accept in the same cycle. That beat counts as delivered, but no advance occurs and done is not pulsed.
- **Handshake stability.** While ivar_valid=1 and ivar_ready=0, ivar_i, ivar_j and ivar_last hold stable.

## Timing

- **Reset values.** All outputs are 0: ivar_i=0, ivar_j=0, ivar_valid=0, ivar_last=0, busy=0, done=0, cfg_err=0. Config registers reset to 0, giving a single-point domain (0,0) with step 1. State resets to IDLE.
- **Reset mid-run.** Takes effect at the next edge. No done pulse is issued and config is cleared.
- **Start latency.** With start at edge k, ivar_valid=1 and busy=1 from cycle k+1, presenting (i_min, j_min).
- **Throughput.** One point per cycle while ivar_ready=1. The next point appears the cycle after acceptance, with no bubbles, including across row wrap.
- **Completion.** The last point is accepted at edge n. At cycle n+1, ivar_valid=0, busy=0 and done=1. IDLE follows at n+2. A start at n+1 is ignored.
- **Empty domain.** Start at edge k gives done=1 and cfg_err=1 at cycle k+1, with busy staying 0.
- **Abort.** Abort at edge k gives ivar_valid=0 and busy=0 at k+1. ivar_i and ivar_j hold their last values.

## Test plan

- **Basic 2×3 domain.** i 0..1, j 0..2, step 1, ready tied high → 6 consecutive beats (0,0)(0,1)(0,2)(1,0)(1,1)(1,2). ivar_last is set on the 6th beat only; done one cycle later; busy is high for exactly 6 cycles.
- **Backpressure.** i -2..-1, j -1..3, step 2, ready toggling 1/0 → beats (-2,-1)(-2,1)(-2,3)(-1,-1)(-1,1)(-1,3). Outputs stay stable during ready=0 cycles.
- **Overflow bounds.** W=16, i 32766..32767, j 32765..32767, step 2 → (32766,32765)(32766,32767)(32767,32765)(32767,32767). No wrap; last is flagged on the 4th beat.
- **Empty domain.** j_min=5, j_max=4, then start → no valid beat; done and cfg_err at +1 cycle. cfg_err clears after the next cfg_load.
- **Abort and ignored commands.** Abort after the 3rd accepted beat of a 4×4 domain → valid and busy drop next cycle, no done. cfg_load asserted in RUN leaves the bounds unchanged on the next run.
- **Reset mid-run.** reset_n=0 for one cycle mid-run → all outputs 0 next cycle. A following start runs the single point (0,0) and pulses done.
